// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and the DMA engine.
package dm_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } dmaState_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // A burst base must be word aligned and fall inside the addressable memory.
  function automatic logic baseValid(input logic [31:0] base, input int unsigned addrW);
    logic [31:0] hi;
    hi = base >> (addrW + 2);
    return (base[1:0] == 2'b00) && (hi == '0);
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// CPU, DMA and memory-side signals of the data-memory port arbiter.
interface dm_port_arbiter_if #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned BURST_W = 4
);
  logic               cpu_req;
  logic               cpu_we;
  logic [3:0]         cpu_be;
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic [31:0]        cpu_rdata;
  logic               cpu_stall;

  logic               dma_start;
  logic               dma_we;
  logic [31:0]        dma_base;
  logic [BURST_W-1:0] dma_len;
  logic [31:0]        dma_wdata;
  logic               dma_wready;
  logic [31:0]        dma_rdata;
  logic               dma_rvalid;
  logic               dma_busy;
  logic               dma_done;
  logic               dma_err;

  logic               mem_we;
  logic [3:0]         mem_be;
  logic [ADDR_W-1:0]  mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  // Arbiter view.
  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_start, dma_we, dma_base, dma_len, dma_wdata,
    output dma_wready, dma_rdata, dma_rvalid, dma_busy, dma_done, dma_err,
    output mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment view: pipeline, DMA engine and memory.
  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_start, dma_we, dma_base, dma_len, dma_wdata,
    input  dma_wready, dma_rdata, dma_rvalid, dma_busy, dma_done, dma_err,
    input  mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_burst_counter.sv
// DMA burst address/beat counter: loads on start, advances one word per
// DMA-won beat, wraps at the top of memory and flags the last beat.
module dm_burst_counter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [ADDR_W-1:0]  loadAddr,
  input  logic [BURST_W-1:0] loadLen,
  input  logic               step,
  output logic [ADDR_W-1:0]  addrQ,
  output logic               lastBeat
);

  logic [BURST_W-1:0] beat;
  logic [BURST_W-1:0] lenQ;

  // Address wraps naturally modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      addrQ <= '0;
      beat  <= '0;
      lenQ  <= '0;
    end else if (load) begin
      addrQ <= loadAddr;
      beat  <= '0;
      lenQ  <= loadLen;
    end else if (step) begin
      addrQ <= addrQ + ADDR_W'(1);
      beat  <= beat + BURST_W'(1);
    end
  end

  assign lastBeat = (beat == lenQ);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the M-stage CPU port and a
// word-burst DMA engine. CPU wins unless it is idle or DMA has waited too long.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned BURST_W  = 4,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  dm_port_arbiter_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  dmaState_t         state;
  logic              weQ;
  logic [WAIT_W-1:0] waitCnt;
  logic [ADDR_W-1:0] addrQ;
  logic              lastBeat;
  logic              inBurst;
  logic              dmaWin;
  logic              startAccept;
  logic              unusedCpuAddrBits;

  assign inBurst     = (state == BURST);
  assign dmaWin      = inBurst && (!bus.cpu_req || (waitCnt == WAIT_LIMIT));
  assign startAccept = (state == IDLE) && bus.dma_start;
  assign unusedCpuAddrBits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};

  dm_burst_counter #(
    .ADDR_W (ADDR_W),
    .BURST_W(BURST_W)
  ) counter (
    .clk     (clk),
    .reset   (reset),
    .load    (startAccept),
    .loadAddr(bus.dma_base[ADDR_W+1:2]),
    .loadLen (bus.dma_len),
    .step    (dmaWin),
    .addrQ   (addrQ),
    .lastBeat(lastBeat)
  );

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = inBurst & bus.cpu_req & dmaWin;
  assign bus.dma_wready = dmaWin & weQ;
  assign bus.dma_busy   = (state != IDLE);

  // Memory port mux; a write is never issued during a reset cycle.
  always_comb begin
    if (dmaWin) begin
      bus.mem_we    = weQ;
      bus.mem_be    = BE_WORD;
      bus.mem_addr  = addrQ;
      bus.mem_wdata = bus.dma_wdata;
    end else begin
      bus.mem_we    = bus.cpu_req & bus.cpu_we;
      bus.mem_be    = bus.cpu_be;
      bus.mem_addr  = bus.cpu_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.cpu_wdata;
    end
    if (reset) bus.mem_we = 1'b0;
  end

  // Burst FSM with registered read-beat data, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      weQ            <= 1'b0;
      waitCnt        <= '0;
      bus.dma_rvalid <= 1'b0;
      bus.dma_rdata  <= '0;
      bus.dma_done   <= 1'b0;
      bus.dma_err    <= 1'b0;
    end else begin
      bus.dma_rvalid <= dmaWin && !weQ;
      bus.dma_done   <= 1'b0;
      if (dmaWin && !weQ) bus.dma_rdata <= bus.mem_rdata;
      case (state)
        IDLE: begin
          if (bus.dma_start) begin
            weQ     <= bus.dma_we;
            waitCnt <= '0;
            if (!baseValid(bus.dma_base, ADDR_W)) begin
              bus.dma_err  <= 1'b1;
              bus.dma_done <= 1'b1;
              state        <= DONE;
            end else begin
              bus.dma_err <= 1'b0;
              state       <= BURST;
            end
          end
        end
        BURST: begin
          if (dmaWin) begin
            waitCnt <= '0;
            if (lastBeat) begin
              bus.dma_done <= 1'b1;
              state        <= DONE;
            end
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized scoreboard bench for dm_port_arbiter with a transaction-level model.
module tb_dm_port_arbiter;

  localparam int MAX_WAIT = 4;

  typedef struct {
    logic [10:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  dm_port_arbiter_if #(.ADDR_W(11), .BURST_W(4)) bus ();

  dm_port_arbiter #(.ADDR_W(11), .BURST_W(4), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem    [2048];
  logic [31:0] refMem [2048];
  beat_t beatQ[$];
  bit    startQ[$];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Environment memory: combinational read, write on posedge.
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= merge(mem[bus.mem_addr], bus.mem_wdata, bus.mem_be);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveCpu(input int mode);
    bus.cpu_req   = (mode == 0) ? 1'b0 : (mode == 2) ? 1'b1 : 1'($urandom);
    bus.cpu_we    = 1'($urandom);
    bus.cpu_be    = 4'($urandom);
    bus.cpu_addr  = $urandom;
    bus.cpu_wdata = $urandom;
  endtask

  task automatic cycle(input int mode);
    @(posedge clk);
    #1;
    bus.dma_start = 1'b0;
    bus.dma_wdata = (beatQ.size() != 0) ? beatQ[0].wdata : $urandom;
    driveCpu(mode);
  endtask

  task automatic runBurst(input logic [31:0] base, input logic [3:0] len, input logic we,
                          input int mode, input bit junk);
    bit    err;
    int    n;
    beat_t b;
    err = !(base[1:0] == 2'b00 && base[31:13] == '0);
    bus.dma_start = 1'b1;
    bus.dma_we    = we;
    bus.dma_base  = base;
    bus.dma_len   = len;
    startQ.push_back(err);
    if (!err) begin
      for (int i = 0; i <= int'(len); i++) begin
        b.addr  = base[12:2] + 11'(i);
        b.we    = we;
        b.wdata = $urandom;
        beatQ.push_back(b);
      end
    end
    bus.dma_wdata = (beatQ.size() != 0) ? beatQ[0].wdata : $urandom;
    cycle(mode);
    if (junk && !err) begin
      bus.dma_start = 1'b1;
      bus.dma_base  = $urandom;
      bus.dma_len   = 4'($urandom);
      bus.dma_we    = 1'($urandom);
    end
    n = 0;
    while (bus.dma_done !== 1'b1 && n < 200) begin
      cycle(mode);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL done_timeout: no dma_done within %0d cycles, base %h", n, base);
    end
    cycle(mode);
  endtask

  task automatic resetMidBurst();
    beat_t b;
    bus.dma_start = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_base  = 32'h400;
    bus.dma_len   = 4'd7;
    startQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b.addr  = 11'(256 + i);
      b.we    = 1'b1;
      b.wdata = $urandom;
      beatQ.push_back(b);
    end
    bus.dma_wdata = beatQ[0].wdata;
    cycle(0);
    cycle(0);
    cycle(0);
    reset = 1'b1;
    cycle(0);
    reset = 1'b0;
    repeat (6) cycle(1);
  endtask

  // Monitor: compares every cycle against the transaction-level model.
  initial begin : monitor
    int          phase;
    int          lost;
    bit          prevRead;
    bit          expErr;
    bit          afterReset;
    bit          win;
    bit          inB;
    logic [31:0] expRd;
    logic [10:0] ca;
    beat_t       b;
    phase = 0; lost = 0; prevRead = 0; expErr = 0; afterReset = 0; expRd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("mem_we_in_reset", 32'(bus.mem_we), 32'd0);
        beatQ.delete();
        startQ.delete();
        phase = 0; lost = 0; prevRead = 0; expErr = 0; afterReset = 1;
      end else begin
        if (afterReset) chk("rdata_after_reset", bus.dma_rdata, 32'd0);
        afterReset = 0;
        chk("dma_busy", 32'(bus.dma_busy), 32'(phase != 0));
        chk("dma_done", 32'(bus.dma_done), 32'(phase == 2));
        chk("dma_err", 32'(bus.dma_err), 32'(expErr));
        chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(prevRead));
        if (prevRead) chk("dma_rdata", bus.dma_rdata, expRd);
        chk("cpu_rdata", bus.cpu_rdata, bus.mem_rdata);
        inB = (phase == 1) && (beatQ.size() != 0);
        win = inB && (!bus.cpu_req || lost == MAX_WAIT);
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(win && bus.cpu_req));
        if (win) begin
          b = beatQ.pop_front();
          chk("dma_mem_addr", 32'(bus.mem_addr), 32'(b.addr));
          chk("dma_mem_be", 32'(bus.mem_be), 32'hF);
          chk("dma_mem_we", 32'(bus.mem_we), 32'(b.we));
          chk("dma_wready", 32'(bus.dma_wready), 32'(b.we));
          if (b.we) chk("dma_mem_wdata", bus.mem_wdata, b.wdata);
          prevRead = !b.we;
          expRd    = refMem[b.addr];
          if (b.we) refMem[b.addr] = b.wdata;
          lost = 0;
          if (beatQ.size() == 0) phase = 2;
        end else begin
          ca = bus.cpu_addr[12:2];
          chk("cpu_mem_addr", 32'(bus.mem_addr), 32'(ca));
          chk("cpu_mem_be", 32'(bus.mem_be), 32'(bus.cpu_be));
          chk("cpu_mem_we", 32'(bus.mem_we), 32'(bus.cpu_req & bus.cpu_we));
          chk("cpu_mem_wdata", bus.mem_wdata, bus.cpu_wdata);
          chk("dma_wready_idle", 32'(bus.dma_wready), 32'd0);
          prevRead = 0;
          if (bus.cpu_req && bus.cpu_we) refMem[ca] = merge(refMem[ca], bus.cpu_wdata, bus.cpu_be);
          if (inB) lost++;
          if (phase == 2) phase = 0;
          else if (phase == 0 && bus.dma_start) begin
            if (startQ.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL start_desc: start seen with no descriptor at %0t", $time);
            end else begin
              expErr = startQ.pop_front();
              phase  = expErr ? 2 : 1;
              lost   = 0;
            end
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized bursts.
  initial begin : stimulus
    logic [31:0] base;
    int          r;
    for (int i = 0; i < 2048; i++) begin
      mem[i]    = $urandom;
      refMem[i] = mem[i];
    end
    reset         = 1'b1;
    bus.dma_start = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_base  = '0;
    bus.dma_len   = '0;
    bus.dma_wdata = '0;
    driveCpu(0);
    repeat (3) cycle(0);
    reset = 1'b0;
    cycle(0);

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_be    = 4'b0011;
    bus.cpu_addr  = 32'h10;
    bus.cpu_wdata = 32'h1234;
    cycle(0);

    runBurst(32'h100, 4'd3, 1'b1, 0, 1'b0);
    runBurst(32'h100, 4'd3, 1'b0, 1, 1'b0);
    runBurst(32'h200, 4'd1, 1'b0, 2, 1'b0);
    runBurst(32'h1FFC, 4'd1, 1'b1, 0, 1'b0);
    runBurst(32'h1FFC, 4'd1, 1'b0, 2, 1'b0);
    runBurst(32'h2002, 4'd3, 1'b1, 1, 1'b0);
    runBurst(32'h102, 4'd0, 1'b0, 0, 1'b0);
    runBurst(32'h2000, 4'd2, 1'b1, 0, 1'b0);
    runBurst(32'h10, 4'd0, 1'b0, 0, 1'b1);
    runBurst(32'h8, 4'd15, 1'b1, 2, 1'b1);
    resetMidBurst();
    runBurst(32'h400, 4'd7, 1'b0, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom % 10);
      if (r == 0) base = $urandom;
      else if (r == 1) base = {19'd0, 11'($urandom), 2'b01};
      else base = {19'd0, 11'($urandom), 2'b00};
      runBurst(base, 4'($urandom), 1'($urandom), int'($urandom % 3), 1'($urandom));
      repeat (int'($urandom % 3)) cycle(1);
    end

    repeat (4) cycle(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
